status_register_stack: RTL and testbench

STATUS_REGISTER_STACK -- requirements
Module: status_register_stack

---
 rtl/status_register_stack.sv | 135 +++++++++++++
 tb/tb_status_register_stack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/status_register_stack.sv
// Status/flag register with a LIFO shadow stack for save/restore.
// Each flag bit is updated by a fixed priority of clear, set, data-bus load,
// zero-detect and ALU load. A push saves the flags onto the stack and a pop
// restores them. Overflow and underflow are reported in sticky error bits.
module status_register_stack #(
  parameter int unsigned         WIDTH          = 8,
  parameter int unsigned         DEPTH          = 4,
  parameter logic [WIDTH-1:0]    RESET_VALUE    = WIDTH'(8'h24),
  parameter logic [WIDTH-1:0]    FIXED_ONE_MASK = WIDTH'(8'h20),
  parameter int unsigned         ZERO_BIT       = 1
) (
  input  logic                           clk_1,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               db_in,
  input  logic [WIDTH-1:0]               alu_flags,
  input  logic [WIDTH-1:0]               alu_mask,
  input  logic [WIDTH-1:0]               db_mask,
  input  logic [WIDTH-1:0]               set_mask,
  input  logic [WIDTH-1:0]               clr_mask,
  input  logic                           dbz_z,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           err_clr,
  input  logic                           p_db,
  output logic [WIDTH-1:0]               flags,
  output logic [WIDTH-1:0]               db_out,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow_err,
  output logic                           underflow_err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  // Slot index width; the array is rounded up to a power of two so any
  // index of this width is in range.
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NSLOT = 1 << IW;
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_CNT  = DW'(1);
  localparam logic [WIDTH-1:0] RESET_FLAGS = RESET_VALUE | FIXED_ONE_MASK;

  logic [WIDTH-1:0] r_flags;
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_stack [NSLOT];

  logic             w_full;
  logic             w_empty;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic             w_db_zero;
  logic [WIDTH-1:0] w_masked;
  logic [WIDTH-1:0] w_next_flags;
  logic [DW-1:0]    w_next_depth;

  assign w_full      = (r_depth == FULL_CNT);
  assign w_empty     = (r_depth == '0);
  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_push_ok   = w_push_only & ~w_full;
  assign w_pop_ok    = w_pop_only & ~w_empty;
  assign w_ovf_evt   = w_push_only & w_full;
  assign w_unf_evt   = w_pop_only & w_empty;
  assign w_wr_idx    = IW'(r_depth);
  assign w_rd_idx    = IW'(r_depth - ONE_CNT);
  assign w_db_zero   = (db_in == '0);

  // Mask-driven flag update, applied lowest priority first so later
  // stages override earlier ones; a valid pop replaces it entirely.
  always_comb begin
    w_masked = r_flags;
    w_masked = (w_masked & ~alu_mask) | (alu_flags & alu_mask);
    if (dbz_z) begin
      w_masked[ZERO_BIT] = w_db_zero;
    end
    w_masked = (w_masked & ~db_mask) | (db_in & db_mask);
    w_masked = w_masked | set_mask;
    w_masked = w_masked & ~clr_mask;
    if (w_pop_ok) begin
      w_next_flags = r_stack[w_rd_idx] | FIXED_ONE_MASK;
    end else begin
      w_next_flags = w_masked | FIXED_ONE_MASK;
    end
  end

  // Stack pointer moves only on an unambiguous, in-range push or pop.
  always_comb begin
    w_next_depth = r_depth;
    if (w_push_ok) begin
      w_next_depth = r_depth + ONE_CNT;
    end else if (w_pop_ok) begin
      w_next_depth = r_depth - ONE_CNT;
    end
  end

  // Flag, depth and sticky error registers.
  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      r_flags <= RESET_FLAGS;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flags <= w_next_flags;
      r_depth <= w_next_depth;
      r_ovf   <= w_ovf_evt | (r_ovf & ~err_clr);
      r_unf   <= w_unf_evt | (r_unf & ~err_clr);
    end
  end

  // Slot storage saves the pre-update flags; contents need no reset
  // because slots at or above depth are never read.
  always_ff @(posedge clk_1) begin
    if (w_push_ok) begin
      r_stack[w_wr_idx] <= r_flags;
    end
  end

  assign flags         = r_flags;
  assign db_out        = p_db ? r_flags : '0;
  assign depth         = r_depth;
  assign full          = w_full;
  assign empty         = w_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: tb/tb_status_register_stack.sv
// Bench for status_register_stack: directed vector table, hand-written
// reset/stack sequences, then randomized traffic against a queue model.
module tb_status_register_stack;

  localparam logic [7:0] FIX = 8'h20;

  logic       clk_1 = 1'b0;
  logic       reset;
  logic [7:0] db_in, alu_flags, alu_mask, db_mask, set_mask, clr_mask;
  logic       dbz_z, push, pop, err_clr, p_db;
  logic [7:0] flags, db_out;
  logic [2:0] depth;
  logic       full, empty, overflow_err, underflow_err;

  int total = 0;
  int bad   = 0;

  status_register_stack #(
    .WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h24), .FIXED_ONE_MASK(8'h20), .ZERO_BIT(1)
  ) dut (
    .clk_1(clk_1), .reset(reset), .db_in(db_in), .alu_flags(alu_flags),
    .alu_mask(alu_mask), .db_mask(db_mask), .set_mask(set_mask),
    .clr_mask(clr_mask), .dbz_z(dbz_z), .push(push), .pop(pop),
    .err_clr(err_clr), .p_db(p_db), .flags(flags), .db_out(db_out),
    .depth(depth), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct {
    logic [7:0] dbi, aluf, alum, dbm, setm, clrm;
    logic       dbz, psh, pp, ec;
    logic [7:0] ef;
    logic [2:0] ed;
    logic       eo, eu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] dbi, logic [7:0] aluf, logic [7:0] alum,
                              logic [7:0] dbm, logic [7:0] setm, logic [7:0] clrm,
                              logic dbz, logic psh, logic pp, logic ec,
                              logic [7:0] ef, logic [2:0] ed, logic eo, logic eu);
    vec_t v;
    v.dbi = dbi; v.aluf = aluf; v.alum = alum; v.dbm = dbm; v.setm = setm;
    v.clrm = clrm; v.dbz = dbz; v.psh = psh; v.pp = pp; v.ec = ec;
    v.ef = ef; v.ed = ed; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    db_in = '0; alu_flags = '0; alu_mask = '0; db_mask = '0;
    set_mask = '0; clr_mask = '0; dbz_z = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk_1);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] ef, input logic [2:0] ed,
                             input logic eo, input logic eu);
    chk({tag, ".flags"}, 32'(flags), 32'(ef));
    chk({tag, ".depth"}, 32'(depth), 32'(ed));
    chk({tag, ".ovf"},   32'(overflow_err), 32'(eo));
    chk({tag, ".unf"},   32'(underflow_err), 32'(eu));
    chk({tag, ".full"},  32'(full), 32'(ed == 3'd4));
    chk({tag, ".empty"}, 32'(empty), 32'(ed == 3'd0));
  endtask

  // Reference model state
  logic [7:0] m_flags;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf;

  task automatic model_step();
    logic [7:0] nf;
    bit push_v, pop_v;
    push_v = push && !pop && m_stk.size() < 4;
    pop_v  = pop && !push && m_stk.size() > 0;
    if (pop_v) begin
      nf = m_stk.pop_back() | FIX;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (clr_mask[b])            nf[b] = 1'b0;
        else if (set_mask[b])       nf[b] = 1'b1;
        else if (db_mask[b])        nf[b] = db_in[b];
        else if (dbz_z && b == 1)   nf[b] = (db_in == 8'h00);
        else if (alu_mask[b])       nf[b] = alu_flags[b];
        else                        nf[b] = m_flags[b];
      end
      nf = nf | FIX;
    end
    if (push_v) m_stk.push_back(m_flags);
    if (push && !pop && m_stk.size() == 4 && !push_v) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
    if (pop && !push && m_stk.size() == 0 && !pop_v) m_unf = 1'b1;
    else if (err_clr) m_unf = 1'b0;
    m_flags = nf;
  endtask

  initial begin
    idle();
    p_db  = 1'b1;
    reset = 1'b1;
    #12;
    // Reset state observable while held, then after release
    chk("rst.flags", 32'(flags), 32'h24);
    @(negedge clk_1);
    reset = 1'b0;
    #1;
    chk("rst.db_out", 32'(db_out), 32'h24);
    check_state("rst", 8'h24, 3'd0, 1'b0, 1'b0);

    // Directed vectors: dbi aluf alum dbm setm clrm dbz psh pp ec | flags depth ovf unf
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'hFF,8'h00,8'h00,0,0,0,0, 8'h20,3'd0,0,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,1,0,0,0, 8'h22,3'd0,0,0));
    vecs.push_back(mk(8'h00,8'h01,8'h01,8'h00,8'h01,8'h01,0,0,0,0, 8'h22,3'd0,0,0));
    vecs.push_back(mk(8'hA1,8'h00,8'h00,8'hFF,8'h00,8'h00,0,0,0,0, 8'hA1,3'd0,0,0));
    vecs.push_back(mk(8'hB2,8'h00,8'h00,8'hFF,8'h00,8'h00,0,1,0,0, 8'hB2,3'd1,0,0));
    vecs.push_back(mk(8'hC3,8'h00,8'h00,8'hFF,8'h00,8'h00,0,1,0,0, 8'hE3,3'd2,0,0));
    vecs.push_back(mk(8'hD4,8'h00,8'h00,8'hFF,8'h00,8'h00,0,1,0,0, 8'hF4,3'd3,0,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,1,0,0, 8'hF4,3'd4,0,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'hFF,8'h00,8'h00,0,1,0,0, 8'h20,3'd4,1,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'hFF,8'h00,0,0,1,0, 8'hF4,3'd3,1,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,0,1,0, 8'hE3,3'd2,1,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,0,1,0, 8'hB2,3'd1,1,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,0,1,0, 8'hA1,3'd0,1,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h80,0,0,0,0, 8'h21,3'd0,1,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h80,8'h00,0,0,1,0, 8'hA1,3'd0,1,1));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,0,0,1, 8'hA1,3'd0,0,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,0,1,1, 8'hA1,3'd0,0,1));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,1,0,1, 8'hA1,3'd1,0,0));
    vecs.push_back(mk(8'h5A,8'h00,8'h00,8'hFF,8'h00,8'h00,0,1,1,0, 8'h7A,3'd1,0,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,0,0,1,0, 8'hA1,3'd0,0,0));
    vecs.push_back(mk(8'h00,8'h05,8'h0F,8'h01,8'h00,8'h00,0,0,0,0, 8'hA4,3'd0,0,0));
    vecs.push_back(mk(8'h01,8'h02,8'h02,8'h00,8'h00,8'h00,1,0,0,0, 8'hA4,3'd0,0,0));
    vecs.push_back(mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF,0,0,0,0, 8'h20,3'd0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_1);
      db_in = vecs[i].dbi; alu_flags = vecs[i].aluf; alu_mask = vecs[i].alum;
      db_mask = vecs[i].dbm; set_mask = vecs[i].setm; clr_mask = vecs[i].clrm;
      dbz_z = vecs[i].dbz; push = vecs[i].psh; pop = vecs[i].pp; err_clr = vecs[i].ec;
      cycle();
      check_state($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ed, vecs[i].eo, vecs[i].eu);
    end

    // Push, push+pop, then asynchronous reset between edges
    @(negedge clk_1); idle(); push = 1; cycle();
    @(negedge clk_1); push = 1; pop = 1; cycle();
    check_state("pushpop", 8'h20, 3'd1, 1'b0, 1'b0);
    @(negedge clk_1); idle();
    #2;
    reset = 1'b1;
    #1;
    chk("async.depth", 32'(depth), 32'd0);
    chk("async.flags", 32'(flags), 32'h24);
    chk("async.empty", 32'(empty), 32'd1);
    @(negedge clk_1);
    reset = 1'b0;
    pop = 1;
    cycle();
    check_state("postrst.pop", 8'h24, 3'd0, 1'b0, 1'b1);

    // Randomized traffic against the queue model
    m_flags = 8'h24; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_1);
      db_in     = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      alu_flags = 8'($urandom);
      alu_mask  = 8'($urandom & $urandom);
      db_mask   = 8'($urandom & $urandom & $urandom);
      set_mask  = 8'($urandom & $urandom & $urandom);
      clr_mask  = 8'($urandom & $urandom & $urandom);
      dbz_z     = ($urandom_range(0, 3) == 0);
      push      = ($urandom_range(0, 2) == 0);
      pop       = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      p_db      = $urandom_range(0, 1) == 1;
      model_step();
      cycle();
      check_state($sformatf("rnd%0d", n), m_flags, 3'(m_stk.size()), m_ovf, m_unf);
      chk($sformatf("rnd%0d.db_out", n), 32'(db_out), p_db ? 32'(m_flags) : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
